// File: rtl/oflow_conflict_resolve_if.sv
`default_nettype none
// ============================================================================
// Module   : oflow_conflict_resolve_if
// Purpose  : Score-board read/write-back bus between the registration score
//            board (master side) and the conflict resolver (slave side).
// Revision : 1.0 - initial release
// ============================================================================
interface oflow_conflict_resolve_if #(
    parameter int MAX_ROWS  = 32,
    parameter int ROW_LEN   = 5,
    parameter int ID_LEN    = 7,
    parameter int SCORE_LEN = 16
);
    logic                   start_cr;
    logic [ROW_LEN:0]       num_of_objects;
    logic [ROW_LEN-1:0]     row_sel_cr;
    logic [2*SCORE_LEN-1:0] score_to_cr;
    logic [2*ID_LEN-1:0]    id_to_cr;
    logic                   write_to_pointer;
    logic [ROW_LEN-1:0]     row_sel_from_cr;
    logic                   data_from_cr;
    logic [MAX_ROWS-1:0]    new_obj_mask;
    logic                   busy;
    logic                   done_cr;

    modport master (
        output start_cr, num_of_objects, score_to_cr, id_to_cr,
        input  row_sel_cr, write_to_pointer, row_sel_from_cr, data_from_cr,
               new_obj_mask, busy, done_cr
    );

    modport slave (
        input  start_cr, num_of_objects, score_to_cr, id_to_cr,
        output row_sel_cr, write_to_pointer, row_sel_from_cr, data_from_cr,
               new_obj_mask, busy, done_cr
    );
endinterface
`default_nettype wire

// File: rtl/oflow_conflict_resolve.sv
`default_nettype none
// ============================================================================
// Module   : oflow_conflict_resolve
// Purpose  : Resolves rows claiming the same previous-frame ID by demoting the
//            worse-scoring row to its second candidate, writing back pointers.
// Revision : 1.0 - initial release
// ============================================================================
module oflow_conflict_resolve #(
    parameter int MAX_ROWS  = 32,
    parameter int ROW_LEN   = 5,
    parameter int ID_LEN    = 7,
    parameter int SCORE_LEN = 16
) (
    input wire logic               clk,
    input wire logic               reset_N,
    oflow_conflict_resolve_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ROW_LEN+1:0] c_pass_max = (ROW_LEN+2)'(2 * MAX_ROWS);

    state_t                 r_state;
    logic [ROW_LEN:0]       r_n;
    logic [ROW_LEN:0]       r_ld;
    logic [ROW_LEN:0]       r_i;
    logic [ROW_LEN:0]       r_j;
    logic [ROW_LEN+1:0]     r_pass;
    logic                   r_changed;
    logic [MAX_ROWS-1:0]    r_ptr;
    logic [MAX_ROWS-1:0]    r_new;
    logic [ROW_LEN-1:0]     r_cap;
    logic [ROW_LEN-1:0]     r_row_sel;
    logic                   r_wr;
    logic [ROW_LEN-1:0]     r_wr_row;
    logic                   r_wr_data;
    logic                   r_busy;
    logic                   r_done;
    logic [ID_LEN-1:0]      r_id0 [MAX_ROWS];
    logic [ID_LEN-1:0]      r_id1 [MAX_ROWS];
    logic [SCORE_LEN-1:0]   r_s0  [MAX_ROWS];
    logic [SCORE_LEN-1:0]   r_s1  [MAX_ROWS];

    logic [ROW_LEN-1:0]     w_ri, w_rj, w_loser;
    logic [ID_LEN-1:0]      w_eid_i, w_eid_j;
    logic [SCORE_LEN-1:0]   w_es_i, w_es_j;
    logic [ROW_LEN:0]       w_ld_nx, w_j_nx, w_i_nx, w_i_nx2;
    logic [ROW_LEN+1:0]     w_pass_nx;
    logic                   w_conflict;

    // Pair indices may run one past the last row when N == 1; w_conflict masks that.
    assign w_ri       = r_i[ROW_LEN-1:0];
    assign w_rj       = r_j[ROW_LEN-1:0];
    assign w_eid_i    = r_ptr[w_ri] ? r_id1[w_ri] : r_id0[w_ri];
    assign w_eid_j    = r_ptr[w_rj] ? r_id1[w_rj] : r_id0[w_rj];
    assign w_es_i     = r_ptr[w_ri] ? r_s1[w_ri] : r_s0[w_ri];
    assign w_es_j     = r_ptr[w_rj] ? r_s1[w_rj] : r_s0[w_rj];
    assign w_loser    = (w_es_i > w_es_j) ? w_ri : w_rj;
    assign w_conflict = (r_j < r_n) && !r_new[w_ri] && !r_new[w_rj] && (w_eid_i == w_eid_j);
    assign w_ld_nx    = r_ld + 1'b1;
    assign w_j_nx     = r_j + 1'b1;
    assign w_i_nx     = r_i + 1'b1;
    assign w_i_nx2    = r_i + 2'd2;
    assign w_pass_nx  = r_pass + 1'b1;

    always_ff @(posedge clk) begin
        if (reset_N) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_ld      <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_changed <= 1'b0;
            r_ptr     <= '0;
            r_new     <= '0;
            r_cap     <= '0;
            r_row_sel <= '0;
            r_wr      <= 1'b0;
            r_wr_row  <= '0;
            r_wr_data <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_id0     <= '{default: '0};
            r_id1     <= '{default: '0};
            r_s0      <= '{default: '0};
            r_s1      <= '{default: '0};
        end else begin
            r_wr      <= 1'b0;
            r_wr_data <= 1'b0;
            r_done    <= 1'b0;
            // Read data lags the address by one cycle, so capture follows the last address.
            r_cap     <= r_row_sel;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_cr) begin
                        r_n       <= bus.num_of_objects;
                        r_ld      <= '0;
                        r_i       <= '0;
                        r_j       <= (ROW_LEN+1)'(1);
                        r_pass    <= '0;
                        r_changed <= 1'b0;
                        r_ptr     <= '0;
                        r_new     <= '0;
                        r_row_sel <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= (bus.num_of_objects == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_ld != '0) begin
                        r_s0[r_cap]  <= bus.score_to_cr[2*SCORE_LEN-1:SCORE_LEN];
                        r_s1[r_cap]  <= bus.score_to_cr[SCORE_LEN-1:0];
                        r_id0[r_cap] <= bus.id_to_cr[2*ID_LEN-1:ID_LEN];
                        r_id1[r_cap] <= bus.id_to_cr[ID_LEN-1:0];
                    end
                    if (w_ld_nx < r_n)
                        r_row_sel <= w_ld_nx[ROW_LEN-1:0];
                    if (r_ld == r_n)
                        r_state <= S_SCAN;
                    else
                        r_ld <= w_ld_nx;
                end
                S_SCAN: begin
                    if (w_conflict) begin
                        if (!r_ptr[w_loser]) begin
                            r_ptr[w_loser] <= 1'b1;
                            r_changed      <= 1'b1;
                            r_wr           <= 1'b1;
                            r_wr_data      <= 1'b1;
                            r_wr_row       <= w_loser;
                        end else begin
                            r_new[w_loser] <= 1'b1;
                        end
                    end
                    if (w_j_nx < r_n) begin
                        r_j <= w_j_nx;
                    end else if (w_i_nx2 < r_n) begin
                        r_i <= w_i_nx;
                        r_j <= w_i_nx2;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_i <= '0;
                    r_j <= (ROW_LEN+1)'(1);
                    if (r_changed) begin
                        r_changed <= 1'b0;
                        r_pass    <= w_pass_nx;
                        r_state   <= (w_pass_nx == c_pass_max) ? S_DONE : S_SCAN;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.row_sel_cr       = r_row_sel;
    assign bus.write_to_pointer = r_wr;
    assign bus.row_sel_from_cr  = r_wr_row;
    assign bus.data_from_cr     = r_wr_data;
    assign bus.new_obj_mask     = r_new;
    assign bus.busy             = r_busy;
    assign bus.done_cr          = r_done;
endmodule
`default_nettype wire
